// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared types and helpers for the PWM fade sequencer.
//   fadeState_t   : sequencer FSM states (IDLE, COMPUTE, WAIT)
//   chanIdxWidth  : width of a channel index, clog2 with a floor of 1 bit
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    WAIT    = 2'd2
  } fadeState_t;

  // A single channel still needs a 1-bit index port.
  function automatic int chanIdxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_fade_step.sv
// pwm_fade_step
// Purely combinational step unit: moves a duty one step toward its target
// without ever overshooting, wrapping or underflowing.
// Ports:
//   i_cur  [BITS-1:0] : current committed duty
//   i_tgt  [BITS-1:0] : target duty
//   i_step [BITS-1:0] : change per period, 0 means jump to target
//   o_next [BITS-1:0] : next duty
module pwm_fade_step #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] i_cur,
  input  logic [BITS-1:0] i_tgt,
  input  logic [BITS-1:0] i_step,
  output logic [BITS-1:0] o_next
);

  logic [BITS-1:0] w_upDist;
  logic [BITS-1:0] w_downDist;

  assign w_upDist   = i_tgt - i_cur;
  assign w_downDist = i_cur - i_tgt;

  // Distances are only consulted on the matching side of the comparison,
  // so the subtractions never wrap where they are used. Snapping to the
  // target when the remaining distance fits in one step keeps cur+step and
  // cur-step inside the range.
  always_comb begin
    o_next = i_cur;
    if (i_cur < i_tgt) begin
      if ((w_upDist <= i_step) || (i_step == '0)) begin
        o_next = i_tgt;
      end else begin
        o_next = i_cur + i_step;
      end
    end else if (i_cur > i_tgt) begin
      if ((w_downDist <= i_step) || (i_step == '0)) begin
        o_next = i_tgt;
      end else begin
        o_next = i_cur - i_step;
      end
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Per-channel brightness ramp scheduler feeding a PWM channel bank. The host
// writes target/step/enable per channel; once per PWM period a single shared
// step unit walks all channels, and the staged results are committed to the
// bank together at the period boundary.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   counter             : shared free-running PWM period counter
//   cfg_valid/cfg_ready : config handshake
//   cfg_channel         : channel index (out-of-range writes are dropped)
//   cfg_target/cfg_step : target duty and per-period step (0 = jump)
//   cfg_enable          : channel enable
//   set_values          : committed duties, channel i at [i*BITS +: BITS]
//   channel_enable      : committed enables
//   ramp_done           : one-cycle pulse when a channel's duty lands on target
//   busy                : any committed duty differs from its target
// Optional feature macro PWM_FADE_IRQ_EN adds irq (sticky, set by any
// ramp_done bit) and irq_clear.
module pwm_fade_sequencer
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int BITS     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [BITS-1:0]                          counter,
  input  logic                                     cfg_valid,
  output logic                                     cfg_ready,
  input  logic [pwm_pkg::chanIdxWidth(CHANNELS)-1:0] cfg_channel,
  input  logic [BITS-1:0]                          cfg_target,
  input  logic [BITS-1:0]                          cfg_step,
  input  logic                                     cfg_enable,
  output logic [BITS*CHANNELS-1:0]                 set_values,
  output logic [CHANNELS-1:0]                      channel_enable,
  output logic [CHANNELS-1:0]                      ramp_done,
  output logic                                     busy
`ifdef PWM_FADE_IRQ_EN
  ,
  input  logic                                     irq_clear,
  output logic                                     irq
`endif
);

  localparam int IW = chanIdxWidth(CHANNELS);

  fadeState_t r_state;
  fadeState_t w_nextState;

  logic [IW-1:0]       r_idx;
  logic [BITS-1:0]     r_target [CHANNELS];
  logic [BITS-1:0]     r_step   [CHANNELS];
  logic [BITS-1:0]     r_staged [CHANNELS];
  logic [BITS-1:0]     r_duty   [CHANNELS];
  logic [CHANNELS-1:0] r_enable;
  logic [CHANNELS-1:0] r_stagedEn;
  logic [CHANNELS-1:0] r_chanEn;
  logic [CHANNELS-1:0] r_rampDone;

  logic            w_start;
  logic            w_computeEn;
  logic            w_commit;
  logic            w_cfgFire;
  logic            w_lastIdx;
  logic [BITS-1:0] w_cur;
  logic [BITS-1:0] w_tgt;
  logic [BITS-1:0] w_stp;
  logic [BITS-1:0] w_next;

  assign w_lastIdx = (r_idx == IW'(CHANNELS - 1));
  assign w_cfgFire = cfg_valid && cfg_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: start the walk at the top of the period, then sit in WAIT
  // until the last count so the commit lands exactly on the wrap.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (counter == '0) w_nextState = COMPUTE;
      COMPUTE: if (w_lastIdx)     w_nextState = WAIT;
      WAIT:    if (counter == '1) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Decoded strobes. Config is held off during the walk so the step unit
  // never sees a target changing under it.
  always_comb begin
    cfg_ready   = 1'b1;
    w_start     = 1'b0;
    w_computeEn = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE:    w_start = (counter == '0);
      COMPUTE: begin
        cfg_ready   = 1'b0;
        w_computeEn = 1'b1;
      end
      WAIT:    w_commit = (counter == '1);
      default: ;
    endcase
  end

  // Select the channel currently being walked for the shared step unit.
  always_comb begin
    w_cur = '0;
    w_tgt = '0;
    w_stp = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_idx == IW'(c)) begin
        w_cur = r_duty[c];
        w_tgt = r_target[c];
        w_stp = r_step[c];
      end
    end
  end

  pwm_fade_step #(.BITS(BITS)) u_step (
    .i_cur  (w_cur),
    .i_tgt  (w_tgt),
    .i_step (w_stp),
    .o_next (w_next)
  );

  // Datapath: config writes, per-channel staging during the walk, and the
  // all-channel commit at the period wrap. ramp_done compares against the
  // duty being replaced so a target rewritten onto the current duty is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_enable   <= '0;
      r_stagedEn <= '0;
      r_chanEn   <= '0;
      r_rampDone <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_target[c] <= '0;
        r_step[c]   <= '0;
        r_staged[c] <= '0;
        r_duty[c]   <= '0;
      end
    end else begin
      r_rampDone <= '0;

      if (w_start) begin
        r_idx <= '0;
      end else if (w_computeEn) begin
        r_idx <= r_idx + IW'(1);
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (w_cfgFire && (cfg_channel == IW'(c))) begin
          r_target[c] <= cfg_target;
          r_step[c]   <= cfg_step;
          r_enable[c] <= cfg_enable;
        end
        if (w_computeEn && (r_idx == IW'(c))) begin
          r_staged[c]   <= w_next;
          r_stagedEn[c] <= r_enable[c];
        end
        if (w_commit) begin
          r_duty[c]     <= r_staged[c];
          r_chanEn[c]   <= r_stagedEn[c];
          r_rampDone[c] <= (r_staged[c] == r_target[c]) && (r_duty[c] != r_target[c]);
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign set_values[g*BITS +: BITS] = r_duty[g];
  end

  assign channel_enable = r_chanEn;
  assign ramp_done      = r_rampDone;

  // busy reflects committed state only, so it rises as soon as a new target
  // is written and falls once the final duty is on the bank.
  always_comb begin
    busy = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_duty[c] != r_target[c]) busy = 1'b1;
    end
  end

`ifdef PWM_FADE_IRQ_EN
  logic r_irq;

  // Sticky interrupt; a new completion wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (|r_rampDone) begin
      r_irq <= 1'b1;
    end else if (irq_clear) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer
// Directed bench for pwm_fade_sequencer with CHANNELS=3, BITS=8. The bench
// owns the period counter and advances it on every falling edge, so the DUT
// samples a stable value on each rising edge and outputs are read mid-cycle.
module tb_pwm_fade_sequencer;

  localparam int CH = 3;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] counter;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_channel;
  logic [BW-1:0] cfg_target;
  logic [BW-1:0] cfg_step;
  logic          cfg_enable;
  logic [BW*CH-1:0] set_values;
  logic [CH-1:0] channel_enable;
  logic [CH-1:0] ramp_done;
  logic          busy;
`ifdef PWM_FADE_IRQ_EN
  logic          irq;
  logic          irq_clear;
`endif

  int checks   = 0;
  int failures = 0;
  int waits;
  int changes;

  pwm_fade_sequencer #(.CHANNELS(CH), .BITS(BW)) dut (
    .clk            (clk),
    .rst            (rst),
    .counter        (counter),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_channel    (cfg_channel),
    .cfg_target     (cfg_target),
    .cfg_step       (cfg_step),
    .cfg_enable     (cfg_enable),
    .set_values     (set_values),
    .channel_enable (channel_enable),
    .ramp_done      (ramp_done),
    .busy           (busy)
`ifdef PWM_FADE_IRQ_EN
    ,
    .irq_clear      (irq_clear),
    .irq            (irq)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; the counter steps on the falling edge.
  task automatic tick();
    @(negedge clk);
    counter = counter + 8'd1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [BW-1:0] duty(input int i);
    return set_values[i*BW +: BW];
  endfunction

  // Run forward until the counter shows v (always at least one tick).
  task automatic gotoCounter(input logic [BW-1:0] v);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((counter != v) && (n < 300));
    if (counter != v) begin
      failures++;
      $error("[TB] FAIL gotoCounter observed=%0d expected=%0d", counter, v);
    end
  endtask

  // One config transfer; waits reports how many cycles ready was held low.
  task automatic applyStimulus(input logic [1:0] ch, input logic [BW-1:0] tgt,
                               input logic [BW-1:0] stp, input logic en,
                               output int nWait);
    logic rdy;
    bit   done;
    nWait       = 0;
    done        = 1'b0;
    cfg_valid   = 1'b1;
    cfg_channel = ch;
    cfg_target  = tgt;
    cfg_step    = stp;
    cfg_enable  = en;
    while (!done) begin
      rdy = cfg_ready;
      tick();
      if (rdy) begin
        done = 1'b1;
      end else begin
        nWait++;
        if (nWait > 20) begin
          failures++;
          $error("[TB] FAIL handshakeTimeout observed=%0d expected<=20", nWait);
          done = 1'b1;
        end
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    counter     = '0;
    cfg_valid   = 1'b0;
    cfg_channel = '0;
    cfg_target  = '0;
    cfg_step    = '0;
    cfg_enable  = 1'b0;
`ifdef PWM_FADE_IRQ_EN
    irq_clear   = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rstSetValues", set_values, 0);
    checkOutput("rstEnable", channel_enable, 0);
    checkOutput("rstReady", cfg_ready, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstRampDone", ramp_done, 0);

    // Ramp up ch0: 0 -> 30 -> 60 -> 90 -> 100
    applyStimulus(2'd0, 8'd100, 8'd30, 1'b1, waits);
    checkOutput("busyAfterWrite", busy, 1);
    checkOutput("dutyBeforeCommit", set_values, 0);
    gotoCounter(0);
    checkOutput("latencyNoCommitYet", duty(0), 0);
    gotoCounter(0);
    checkOutput("rampStep1", duty(0), 30);
    checkOutput("rampEnable", channel_enable, 3'b001);
    checkOutput("rampNoDoneEarly", ramp_done, 0);
    gotoCounter(0);
    checkOutput("rampStep2", duty(0), 60);
    gotoCounter(0);
    checkOutput("rampStep3", duty(0), 90);
    checkOutput("rampBusy", busy, 1);
    gotoCounter(0);
    checkOutput("rampStep4", duty(0), 100);
    checkOutput("rampDonePulse", ramp_done, 3'b001);
    tick();
    checkOutput("rampDoneOneCycle", ramp_done, 0);
    checkOutput("rampBusyFalls", busy, 0);

    // Handshake held off through the three COMPUTE cycles
    checkOutput("readyLowInCompute", cfg_ready, 0);
    applyStimulus(2'd1, 8'd200, 8'd0, 1'b1, waits);
    checkOutput("handshakeWaits", waits, 3);
    gotoCounter(0);
    checkOutput("hsLatency", duty(1), 0);
    gotoCounter(0);
    checkOutput("ch1Jump200", duty(1), 200);
    checkOutput("ch1Done", ramp_done, 3'b010);
    checkOutput("ch1Enable", channel_enable, 3'b011);

    // Ramp down with jump: 200 -> 50
    gotoCounter(10);
    applyStimulus(2'd1, 8'd50, 8'd0, 1'b1, waits);
    gotoCounter(0);
    checkOutput("jumpLatency", duty(1), 200);
    checkOutput("jumpBusy", busy, 1);
    gotoCounter(0);
    checkOutput("jumpDown", set_values, 24'h003264);
    checkOutput("jumpDone", ramp_done, 3'b010);

    // Atomic commit of staggered writes
    gotoCounter(20);
    applyStimulus(2'd0, 8'd10, 8'd0, 1'b1, waits);
    gotoCounter(80);
    applyStimulus(2'd1, 8'd120, 8'd0, 1'b0, waits);
    gotoCounter(150);
    applyStimulus(2'd2, 8'd77, 8'd0, 1'b1, waits);
    gotoCounter(0);
    checkOutput("atomicOldValues", set_values, 24'h003264);
    checkOutput("atomicOldEnable", channel_enable, 3'b011);
    changes = 0;
    repeat (255) begin
      tick();
      if ((set_values !== 24'h003264) || (channel_enable !== 3'b011)) changes++;
    end
    checkOutput("atomicStable", changes, 0);
    tick();
    checkOutput("atomicNewValues", set_values, 24'h4D780A);
    checkOutput("atomicNewEnable", channel_enable, 3'b101);
    checkOutput("atomicDone", ramp_done, 3'b111);
    checkOutput("atomicBusy", busy, 0);

    // Out-of-range channel is accepted and dropped
    gotoCounter(10);
    applyStimulus(2'd3, 8'd200, 8'd0, 1'b1, waits);
    checkOutput("badChanWaits", waits, 0);
    checkOutput("badChanBusy", busy, 0);
    gotoCounter(0);
    gotoCounter(0);
    checkOutput("badChanValues", set_values, 24'h4D780A);
    checkOutput("badChanEnable", channel_enable, 3'b101);

    // Boundaries: 10 -> 255 with step 250, 3 -> 0 with step 5
    gotoCounter(20);
    applyStimulus(2'd0, 8'd255, 8'd250, 1'b1, waits);
    gotoCounter(30);
    applyStimulus(2'd2, 8'd3, 8'd0, 1'b1, waits);
    gotoCounter(0);
    checkOutput("boundLatency", duty(0), 10);
    gotoCounter(0);
    checkOutput("boundNoWrap", duty(0), 255);
    checkOutput("boundCh2At3", duty(2), 3);
    checkOutput("boundDone", ramp_done, 3'b101);
    gotoCounter(10);
    applyStimulus(2'd2, 8'd0, 8'd5, 1'b1, waits);
    gotoCounter(0);
    gotoCounter(0);
    checkOutput("boundNoUnderflow", set_values, 24'h0078FF);
    checkOutput("boundDone2", ramp_done, 3'b100);
    checkOutput("boundBusy", busy, 0);

    // Reset held for two cycles mid-COMPUTE
    tick();
    checkOutput("midComputeReady", cfg_ready, 0);
    rst = 1'b1;
    tick();
    checkOutput("rst2Values1", set_values, 0);
    tick();
    rst = 1'b0;
    checkOutput("rst2Values", set_values, 0);
    checkOutput("rst2Enable", channel_enable, 0);
    checkOutput("rst2Ready", cfg_ready, 1);
    checkOutput("rst2Busy", busy, 0);
    gotoCounter(0);
    gotoCounter(0);
    checkOutput("rst2NoCommit", set_values, 0);
    checkOutput("rst2NoEnable", channel_enable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
